// File: rtl/rotator_arbiter.sv
// rotator_arbiter: two-requester round-robin arbiter that shares one 8-bit
// bidirectional rotator. A command is granted in IDLE, rotated in CALC, and
// its result is held in HOLD until the consumer takes it. Per-requester
// saturating grant counters are kept for debug and fairness checks.

// Combinational 8-bit rotator: lr=1 rotates left, lr=0 rotates right,
// by 0..7 positions. Each output bit is a mux over the source bit index.
module Bidirection_Rotation (
   input  logic [7:0] data,
   input  logic       lr,
   input  logic [2:0] amount,
   output logic [7:0] result
);

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_bit
         localparam logic [2:0] POS = 3'(gi);
         logic [2:0] left_src;
         logic [2:0] right_src;

         // 3-bit index arithmetic wraps modulo 8, which is exactly a rotation
         assign left_src  = POS - amount;
         assign right_src = POS + amount;
         assign result[gi] = lr ? data[left_src] : data[right_src];
      end
   endgenerate

endmodule

module rotator_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,

   input  logic             req0_valid,
   input  logic [7:0]       req0_data,
   input  logic             req0_lr,
   input  logic [2:0]       req0_amount,
   output logic             req0_ready,

   input  logic             req1_valid,
   input  logic [7:0]       req1_data,
   input  logic             req1_lr,
   input  logic [2:0]       req1_amount,
   output logic             req1_ready,

   output logic             out_valid,
   output logic [7:0]       out_data,
   output logic             out_id,
   input  logic             out_ready,

   output logic             busy,
   output logic [CNT_W-1:0] gnt_cnt0,
   output logic [CNT_W-1:0] gnt_cnt1
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state;
   state_t           state_next;

   logic             last;        // requester granted most recently
   logic             winner;      // arbitration result for this cycle
   logic             accept;      // a command is taken on this edge
   logic             is_idle;

   logic [7:0]       op_data;
   logic             op_lr;
   logic [2:0]       op_amt;
   logic [7:0]       rot_result;

   logic [CNT_W-1:0] gnt_cnt [2];

   // The rotator only ever sees registered operands, never live requester inputs
   Bidirection_Rotation u_rot (
      .data   (op_data),
      .lr     (op_lr),
      .amount (op_amt),
      .result (rot_result)
   );

   assign is_idle = (state == IDLE);
   assign busy    = ~is_idle;

   // Arbitration: a lone request wins; on a tie the requester that was not last wins
   always_comb begin
      winner = 1'b0;
      if (req0_valid && req1_valid) begin
         winner = ~last;
      end else if (req1_valid) begin
         winner = 1'b1;
      end
   end

   assign req0_ready = is_idle & req0_valid & ~winner;
   assign req1_ready = is_idle & req1_valid &  winner;
   assign accept     = req0_ready | req1_ready;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state: accept -> CALC -> HOLD -> (out_ready) -> IDLE
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept)    state_next = CALC;
         CALC:                state_next = HOLD;
         HOLD: if (out_ready) state_next = IDLE;
         default:             state_next = IDLE;
      endcase
   end

   // Operand capture and grant bookkeeping on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_data <= 8'h00;
         op_lr   <= 1'b0;
         op_amt  <= 3'd0;
         out_id  <= 1'b0;
         last    <= 1'b1;
      end else if (accept) begin
         op_data <= winner ? req1_data   : req0_data;
         op_lr   <= winner ? req1_lr     : req0_lr;
         op_amt  <= winner ? req1_amount : req0_amount;
         out_id  <= winner;
         last    <= winner;
      end
   end

   // Result register: loaded in CALC, held through HOLD until consumed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= 8'h00;
      end else begin
         if (state == CALC) begin
            out_data  <= rot_result;
            out_valid <= 1'b1;
         end else if (state == HOLD && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Per-requester grant counters, saturating at all ones
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_cnt
         localparam logic ID = 1'(gi);

         // Count a grant to this requester unless already saturated
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               gnt_cnt[gi] <= '0;
            end else if (accept && (winner == ID) && (gnt_cnt[gi] != {CNT_W{1'b1}})) begin
               gnt_cnt[gi] <= gnt_cnt[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   endgenerate

   assign gnt_cnt0 = gnt_cnt[0];
   assign gnt_cnt1 = gnt_cnt[1];

endmodule
